// File: rtl/branch_ckpt_alloc.sv
// Dispatch-side branch-stack checkpoint writer: allocates entries to dispatching
// branches, builds per-slot dependency masks and drives per-entry checkpoint data.
module branch_ckpt_alloc #(
  parameter int unsigned N         = 3,
  parameter int unsigned BS_DEPTH  = 4,
  parameter int unsigned ROB_BITS  = 5,
  parameter int unsigned PREG      = 64,
  parameter int unsigned PREG_BITS = 6,
  parameter int unsigned AREG      = 32,
  parameter int unsigned PC_W      = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N-1:0]                       disp_valid,
  input  logic [N-1:0]                       disp_is_br,
  input  logic [N*PC_W-1:0]                  disp_recovery_pc,
  input  logic [N*ROB_BITS-1:0]              disp_rob_tail,
  input  logic [N*AREG*PREG_BITS-1:0]        disp_map,
  input  logic [N*PREG-1:0]                  disp_free,
  input  logic                               res_valid,
  input  logic [BS_DEPTH-1:0]                res_bmm,
  input  logic                               res_mispred,
  output logic [$clog2(N+1)-1:0]             accept_cnt,
  output logic [N*BS_DEPTH-1:0]              disp_bmask,
  output logic [N*BS_DEPTH-1:0]              disp_own,
  output logic [BS_DEPTH-1:0]                ckpt_wr,
  output logic [BS_DEPTH*PC_W-1:0]           ckpt_pc,
  output logic [BS_DEPTH*ROB_BITS-1:0]       ckpt_rob_tail,
  output logic [BS_DEPTH*AREG*PREG_BITS-1:0] ckpt_map,
  output logic [BS_DEPTH*PREG-1:0]           ckpt_free,
  output logic [BS_DEPTH*BS_DEPTH-1:0]       ckpt_dep,
  output logic [BS_DEPTH-1:0]                next_b_mask,
  output logic                               full
);

  localparam int unsigned CNT_W  = $clog2(N + 1);
  localparam int unsigned FREE_W = $clog2(BS_DEPTH + 1);
  localparam int unsigned MAP_W  = AREG * PREG_BITS;

  logic [BS_DEPTH-1:0]                active_q, active_d;
  logic [BS_DEPTH-1:0][BS_DEPTH-1:0]  dep_q, dep_d;

  logic                               res_apply, squash;
  logic [BS_DEPTH-1:0]                clear, alive, res_drop;

  logic [BS_DEPTH-1:0]                free_mask, avail, alloc_mask;
  logic [FREE_W-1:0]                  nfree, br_cnt;
  logic [CNT_W-1:0]                   acc_cnt;
  logic                               stop;
  logic [N-1:0][BS_DEPTH-1:0]         own, bmask;

  logic [BS_DEPTH-1:0]                wr;
  logic [BS_DEPTH-1:0][PC_W-1:0]      wr_pc;
  logic [BS_DEPTH-1:0][ROB_BITS-1:0]  wr_rob;
  logic [BS_DEPTH-1:0][MAP_W-1:0]     wr_map;
  logic [BS_DEPTH-1:0][PREG-1:0]      wr_free;
  logic [BS_DEPTH-1:0][BS_DEPTH-1:0]  wr_dep;
  logic [BS_DEPTH-1:0]                next_b;

  // Resolution: a mispredict also kills every entry that depends on the branch
  always_comb begin
    clear     = '0;
    res_apply = res_valid && ((res_bmm & active_q) != '0);
    squash    = res_apply && res_mispred;
    res_drop  = res_apply ? res_bmm : '0;
    if (res_apply) begin
      clear = res_bmm;
      if (res_mispred) begin
        for (int unsigned e = 0; e < BS_DEPTH; e++) begin
          if ((dep_q[e] & res_bmm) != '0) clear[e] = 1'b1;
        end
      end
    end
    alive = active_q & ~clear;
  end

  // In-order acceptance; entries freed this cycle are not offered until next cycle
  always_comb begin
    free_mask  = ~active_q;
    nfree      = '0;
    for (int unsigned e = 0; e < BS_DEPTH; e++) begin
      nfree = nfree + FREE_W'(free_mask[e]);
    end
    avail      = free_mask;
    alloc_mask = '0;
    br_cnt     = '0;
    acc_cnt    = '0;
    stop       = squash;
    own        = '0;
    bmask      = '0;
    for (int unsigned s = 0; s < N; s++) begin
      if (!stop && disp_valid[s] && (!disp_is_br[s] || (br_cnt < nfree))) begin
        bmask[s] = alive | alloc_mask;
        acc_cnt  = acc_cnt + CNT_W'(1);
        if (disp_is_br[s]) begin
          own[s]     = avail & (~avail + BS_DEPTH'(1));
          avail      = avail & ~own[s];
          alloc_mask = alloc_mask | own[s];
          br_cnt     = br_cnt + FREE_W'(1);
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Route each owning slot's snapshot to its entry; unwritten entries stay zero
  always_comb begin
    wr      = '0;
    wr_pc   = '0;
    wr_rob  = '0;
    wr_map  = '0;
    wr_free = '0;
    wr_dep  = '0;
    for (int unsigned s = 0; s < N; s++) begin
      for (int unsigned e = 0; e < BS_DEPTH; e++) begin
        if (own[s][e]) begin
          wr[e]      = 1'b1;
          wr_pc[e]   = disp_recovery_pc[s*PC_W +: PC_W];
          wr_rob[e]  = disp_rob_tail[s*ROB_BITS +: ROB_BITS];
          wr_map[e]  = disp_map[s*MAP_W +: MAP_W];
          wr_free[e] = disp_free[s*PREG +: PREG];
          wr_dep[e]  = bmask[s];
        end
      end
    end
  end

  always_comb begin
    next_b   = alive | alloc_mask;
    active_d = next_b;
    dep_d    = dep_q;
    for (int unsigned e = 0; e < BS_DEPTH; e++) begin
      if (alloc_mask[e])  dep_d[e] = wr_dep[e];
      else if (clear[e])  dep_d[e] = '0;
      else                dep_d[e] = dep_q[e] & ~res_drop;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= '0;
      dep_q    <= '0;
    end else begin
      active_q <= active_d;
      dep_q    <= dep_d;
    end
  end

  assign accept_cnt    = reset ? '0 : acc_cnt;
  assign disp_bmask    = reset ? '0 : bmask;
  assign disp_own      = reset ? '0 : own;
  assign ckpt_wr       = reset ? '0 : wr;
  assign ckpt_pc       = reset ? '0 : wr_pc;
  assign ckpt_rob_tail = reset ? '0 : wr_rob;
  assign ckpt_map      = reset ? '0 : wr_map;
  assign ckpt_free     = reset ? '0 : wr_free;
  assign ckpt_dep      = reset ? '0 : wr_dep;
  assign next_b_mask   = reset ? '0 : next_b;
  assign full          = reset ? 1'b0 : (&active_q);

endmodule
